// File: rtl/lcd_char_writer.sv
// HD44780 16x2 character writer: power-on init, then one character per valid/ready
// handshake with cursor tracking, automatic line changes and display clear.
module lcd_char_writer #(
  parameter int unsigned INIT_WAIT_CYC = 1500000,
  parameter int unsigned E_PULSE_CYC   = 24,
  parameter int unsigned CMD_WAIT_CYC  = 4000,
  parameter int unsigned CLR_WAIT_CYC  = 164000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       clear_req,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic [4:0] cursor_pos
);

  typedef enum logic [2:0] {StInitWait, StIdle, StSetup, StPulse, StHold} state_e;
  // What the byte on the bus is for; decides the follow-up when its hold ends.
  typedef enum logic [2:0] {OpInit, OpData, OpNewline, OpLine, OpClear} op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic [4:0]  cursor_q, cursor_d;
  logic        init_done_q, init_done_d;
  logic        clr_pend_q, clr_pend_d;

  logic        clr_eff;
  logic        accept;
  logic        printable;
  logic [31:0] hold_len;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    unique case (idx)
      2'd0:    cmd = 8'h38;
      2'd1:    cmd = 8'h0C;
      2'd2:    cmd = 8'h06;
      default: cmd = 8'h01;
    endcase
    return cmd;
  endfunction

  // A same-cycle clear request already outranks a character in IDLE.
  assign clr_eff    = clr_pend_q | (clear_req & init_done_q);
  assign char_ready = (state_q == StIdle) & init_done_q & ~clr_eff & ~reset;
  assign accept     = char_valid & char_ready;
  assign printable  = (char_in >= 8'h20) && (char_in <= 8'h7E);
  assign hold_len   = (!rs_q && data_q == 8'h01) ? CLR_WAIT_CYC : CMD_WAIT_CYC;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    rs_d        = rs_q;
    data_d      = data_q;
    cursor_d    = cursor_q;
    init_done_d = init_done_q;
    clr_pend_d  = clr_pend_q;

    if (clear_req && init_done_q) begin
      clr_pend_d = 1'b1;
    end

    unique case (state_q)
      StInitWait: begin
        if (cnt_q == INIT_WAIT_CYC - 32'd1) begin
          cnt_d      = '0;
          state_d    = StSetup;
          op_d       = OpInit;
          init_idx_d = 2'd0;
          rs_d       = 1'b0;
          data_d     = init_cmd(2'd0);
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      StIdle: begin
        if (clr_eff) begin
          state_d = StSetup;
          op_d    = OpClear;
          rs_d    = 1'b0;
          data_d  = 8'h01;
        end else if (accept) begin
          if (printable) begin
            state_d = StSetup;
            op_d    = OpData;
            rs_d    = 1'b1;
            data_d  = char_in;
          end else if (char_in == 8'h0A) begin
            state_d = StSetup;
            op_d    = OpNewline;
            rs_d    = 1'b0;
            data_d  = cursor_q[4] ? 8'h80 : 8'hC0;
          end
          // Any other character is consumed without bus activity.
        end
      end

      StSetup: begin
        state_d = StPulse;
        cnt_d   = '0;
      end

      StPulse: begin
        if (cnt_q == E_PULSE_CYC - 32'd1) begin
          cnt_d   = '0;
          state_d = StHold;
          if (op_q == OpData) begin
            cursor_d = cursor_q + 5'd1;
          end else if (op_q == OpNewline) begin
            cursor_d = cursor_q[4] ? 5'd0 : 5'd16;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      StHold: begin
        if (cnt_q == hold_len - 32'd1) begin
          cnt_d   = '0;
          state_d = StIdle;
          unique case (op_q)
            OpInit: begin
              if (init_idx_q == 2'd3) begin
                init_done_d = 1'b1;
                cursor_d    = '0;
              end else begin
                init_idx_d = init_idx_q + 2'd1;
                state_d    = StSetup;
                rs_d       = 1'b0;
                data_d     = init_cmd(init_idx_q + 2'd1);
              end
            end
            OpData: begin
              // Cursor already advanced; a line boundary needs a DDRAM address set.
              if (cursor_q[3:0] == 4'd0) begin
                state_d = StSetup;
                op_d    = OpLine;
                rs_d    = 1'b0;
                data_d  = cursor_q[4] ? 8'hC0 : 8'h80;
              end
            end
            OpClear: begin
              cursor_d   = '0;
              clr_pend_d = 1'b0;
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: state_d = StInitWait;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StInitWait;
      op_q        <= OpInit;
      cnt_q       <= '0;
      init_idx_q  <= 2'd0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      cursor_q    <= '0;
      init_done_q <= 1'b0;
      clr_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      cursor_q    <= cursor_d;
      init_done_q <= init_done_d;
      clr_pend_q  <= clr_pend_d;
    end
  end

  assign lcd_e      = (state_q == StPulse);
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = data_q;
  assign init_done  = init_done_q;
  assign cursor_pos = cursor_q;

endmodule
